// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter and its users.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter and fixed-length access sequencer for the shared asynchronous SRAM.
// The CPU wins ties, except that a DMA request passed over MAX_WAIT times is forced through.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_CYCLES = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Dout_en,
    input  logic [DATA_W-1:0] Mem_Din
);

    localparam int CNT_W  = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t              state, next_state;
    owner_t              owner, grant_owner;
    logic                grant;
    logic                capture;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WAIT_W-1:0]   dma_wait;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        grant       = 1'b0;
        grant_owner = OWN_CPU;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant      = 1'b1;
                    next_state = ACC;
                    if (dma_req && (!cpu_req || dma_wait == WAIT_MAX))
                        grant_owner = OWN_DMA;
                end
            end
            ACC: begin
                if (cnt_q == CNT_LAST) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Request fields are latched at grant so the SRAM sees a stable address for the whole strobe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            owner   <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (grant) begin
            owner   <= grant_owner;
            we_q    <= (grant_owner == OWN_DMA) ? dma_we    : cpu_we;
            addr_q  <= (grant_owner == OWN_DMA) ? dma_addr  : cpu_addr;
            wdata_q <= (grant_owner == OWN_DMA) ? dma_wdata : cpu_wdata;
            cnt_q   <= '0;
        end else if (state == ACC) begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the read-data holding registers are reset so software never sees stale data after Reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else if (capture && !we_q) begin
            if (owner == OWN_DMA) dma_rdata <= Mem_Din;
            else                  cpu_rdata <= Mem_Din;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || !dma_req)
            dma_wait <= '0;
        else if (grant) begin
            if (grant_owner == OWN_DMA)
                dma_wait <= '0;
            else if (dma_wait != WAIT_MAX)
                dma_wait <= dma_wait + WAIT_W'(1);
        end
    end

    // Pins decode registered state only; WE and Dout_en share one term so they switch together.
    assign cpu_ack     = (state == DONE) && (owner == OWN_CPU);
    assign dma_ack     = (state == DONE) && (owner == OWN_DMA);
    assign Mem_CE      = 1'b0;
    assign Mem_UB      = 1'b0;
    assign Mem_LB      = 1'b0;
    assign Mem_OE      = !((state == ACC) && !we_q);
    assign Mem_WE      = !((state == ACC) && we_q);
    assign Mem_Dout_en = (state == ACC) && we_q;
    assign Mem_ADDR    = addr_q;
    assign Mem_Dout    = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with default parameters (ACC_CYCLES=2, MAX_WAIT=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [19:0] cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Dout_en;
    logic [19:0] Mem_ADDR;
    logic [15:0] Mem_Dout, Mem_Din;

    int checks = 0;
    int errors = 0;

    sram_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_ADDR(Mem_ADDR), .Mem_Dout(Mem_Dout), .Mem_Dout_en(Mem_Dout_en), .Mem_Din(Mem_Din)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Strobe/ack pins packed as {cpu_ack, dma_ack, Mem_OE, Mem_WE, Mem_Dout_en}
    function automatic logic [4:0] pins();
        return {cpu_ack, dma_ack, Mem_OE, Mem_WE, Mem_Dout_en};
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (pins() !== 5'b00110) begin
                errors++;
                $display("FAIL reset_pins cycle %0d got %b exp 00110", c, pins());
            end
            checks++;
            if ({cpu_rdata, dma_rdata} !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata cycle %0d got %h exp 00000000", c, {cpu_rdata, dma_rdata});
            end
        end
        checks++;
        if ({Mem_CE, Mem_UB, Mem_LB, Mem_ADDR, Mem_Dout} !== 39'h0) begin
            errors++;
            $display("FAIL reset_mem got ce/ub/lb=%b%b%b addr=%h dout=%h exp all 0",
                     Mem_CE, Mem_UB, Mem_LB, Mem_ADDR, Mem_Dout);
        end
    endtask

    task automatic test_cpu_read();
        cpu_we = 1'b0; cpu_addr = 20'h00003; Mem_Din = 16'hBEEF;
        cpu_req = 1'b1;                              // cycle 0
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (pins() !== 5'b00010 || Mem_ADDR !== 20'h00003) begin
                errors++;
                $display("FAIL cpu_read_acc cycle %0d got pins=%b addr=%h exp pins=00010 addr=00003",
                         c, pins(), Mem_ADDR);
            end
        end
        tick();                                      // cycle 3
        checks++;
        if (pins() !== 5'b10110) begin
            errors++;
            $display("FAIL cpu_read_ack got pins=%b exp 10110", pins());
        end
        checks++;
        if (cpu_rdata !== 16'hBEEF || dma_rdata !== 16'h0) begin
            errors++;
            $display("FAIL cpu_read_data got cpu=%h dma=%h exp cpu=beef dma=0000", cpu_rdata, dma_rdata);
        end
        cpu_req = 1'b0;
        tick();                                      // cycle 4
        checks++;
        if (pins() !== 5'b00110 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL cpu_read_idle got pins=%b state=%0d exp pins=00110 IDLE", pins(), dut.state);
        end
    endtask

    task automatic test_dma_write();
        dma_we = 1'b1; dma_addr = 20'h00010; dma_wdata = 16'h1234; Mem_Din = 16'h7777;
        dma_req = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (pins() !== 5'b00101 || Mem_ADDR !== 20'h00010 || Mem_Dout !== 16'h1234) begin
                errors++;
                $display("FAIL dma_write_acc cycle %0d got pins=%b addr=%h dout=%h exp 00101 00010 1234",
                         c, pins(), Mem_ADDR, Mem_Dout);
            end
        end
        tick();
        checks++;
        if (pins() !== 5'b01110) begin
            errors++;
            $display("FAIL dma_write_ack got pins=%b exp 01110", pins());
        end
        checks++;
        if (dma_rdata !== 16'h0 || cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL dma_write_rdata got cpu=%h dma=%h exp cpu=beef dma=0000", cpu_rdata, dma_rdata);
        end
        dma_req = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        logic exp_dma;
        cpu_we = 1'b0; cpu_addr = 20'h00020;
        dma_we = 1'b0; dma_addr = 20'h00030;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_dma = (g == 4);
            Mem_Din = 16'h1000 + 16'(g);
            tick();                                  // first ACC cycle
            checks++;
            if (Mem_ADDR !== (exp_dma ? 20'h00030 : 20'h00020)) begin
                errors++;
                $display("FAIL arb_addr grant %0d got %h exp %h", g, Mem_ADDR,
                         exp_dma ? 20'h00030 : 20'h00020);
            end
            tick();
            tick();                                  // DONE cycle
            checks++;
            if ({cpu_ack, dma_ack} !== {!exp_dma, exp_dma}) begin
                errors++;
                $display("FAIL arb_ack grant %0d got cpu=%b dma=%b exp cpu=%b dma=%b",
                         g, cpu_ack, dma_ack, !exp_dma, exp_dma);
            end
            checks++;
            if ((exp_dma ? dma_rdata : cpu_rdata) !== 16'h1000 + 16'(g)) begin
                errors++;
                $display("FAIL arb_rdata grant %0d got %h exp %h", g,
                         exp_dma ? dma_rdata : cpu_rdata, 16'h1000 + 16'(g));
            end
            if (g == 5) begin
                cpu_req = 1'b0; dma_req = 1'b0;
            end
            tick();                                  // IDLE cycle
        end
    endtask

    task automatic test_reset_abort();
        cpu_we = 1'b1; cpu_addr = 20'h00040; cpu_wdata = 16'hA5A5;
        cpu_req = 1'b1;
        tick();                                      // first ACC cycle of the write
        checks++;
        if (Mem_WE !== 1'b0 || Mem_Dout_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got we=%b en=%b exp we=0 en=1", Mem_WE, Mem_Dout_en);
        end
        Reset = 1'b1; cpu_req = 1'b0;
        tick();
        checks++;
        if (Mem_WE !== 1'b1 || Mem_Dout_en !== 1'b0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL abort_post got we=%b en=%b state=%0d exp we=1 en=0 IDLE",
                     Mem_WE, Mem_Dout_en, dut.state);
        end
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({cpu_ack, dma_ack} !== 2'b00) begin
                errors++;
                $display("FAIL abort_noack step %0d got cpu=%b dma=%b exp 0 0", c, cpu_ack, dma_ack);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        cpu_we = 1'b0; cpu_addr = 20'h00050; Mem_Din = 16'h1111;
        cpu_req = 1'b1;                              // cycle 0
        tick(); tick(); tick();                      // cycle 3
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_first got ack=%b rdata=%h exp ack=1 rdata=1111", cpu_ack, cpu_rdata);
        end
        cpu_addr = 20'h00051; Mem_Din = 16'h2222;    // req stays high
        tick();                                      // cycle 4: new grant
        checks++;
        if (dut.state !== IDLE || cpu_ack !== 1'b0 || cpu_rdata !== 16'h1111) begin
            errors++;
            $display("FAIL b2b_idle got state=%0d ack=%b rdata=%h exp IDLE 0 1111",
                     dut.state, cpu_ack, cpu_rdata);
        end
        for (int c = 5; c <= 6; c++) begin
            tick();
            checks++;
            if (Mem_OE !== 1'b0 || Mem_ADDR !== 20'h00051 || cpu_rdata !== 16'h1111) begin
                errors++;
                $display("FAIL b2b_acc cycle %0d got oe=%b addr=%h rdata=%h exp 0 00051 1111",
                         c, Mem_OE, Mem_ADDR, cpu_rdata);
            end
        end
        tick();                                      // cycle 7
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL b2b_second got ack=%b rdata=%h exp ack=1 rdata=2222", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        Mem_Din = '0;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_arbitration();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
